mem_port_arbiter: RTL

//  Parametrised arbiter merging NUM_CH cache system-side channels (I-cache, D-cache, ...) onto one

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// arbitration mode selectors.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner select: fixed priority (lowest index) or round-robin
// search starting at ptr. Produces one-hot grant, its index and an any flag.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned IDX_W   = 1,
  parameter int unsigned RR_MODE = 0
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any
);

  logic [31:0] start;
  logic [31:0] best_d;
  logic [31:0] best_i;
  logic [31:0] d;

  // Rank each requester by its rotational distance from the start point;
  // the smallest distance wins.
  always_comb begin
    start     = (RR_MODE == MODE_RR) ? 32'(ptr) : '0;
    best_d    = 32'(NUM_CH);
    best_i    = '0;
    d         = '0;
    any       = 1'b0;
    grant     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (req[i]) begin
        d = (32'(i) + 32'(NUM_CH) - start) % 32'(NUM_CH);
        if (d < best_d) begin
          best_d = d;
          best_i = 32'(i);
          any    = 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      grant[i] = any && (best_i == 32'(i));
    end
    grant_idx = IDX_W'(best_i);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges NUM_CH cache channels onto one single-ported memory interface with
// fixed-priority or round-robin arbitration and a memory-timeout abort.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_ADDR_W = 12,
  parameter int unsigned RR_MODE    = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_strobe,
  input  logic [NUM_CH-1:0]        ch_rw,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic                     ch_err,
  output logic                     mem_enable,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [MEM_ADDR_W-1:0]    mem_address,
  output logic [DATA_W-1:0]        mem_in,
  input  logic [DATA_W-1:0]        mem_out,
  input  logic                     mem_ready,
  output logic                     busy
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t state_q, state_d;

  logic [NUM_CH-1:0]     gnt_oh;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      ptr_next;
  logic [NUM_CH-1:0]     sel_oh_q;
  logic                  rw_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  timeout_hit;
  logic                  sel_rw;
  logic [MEM_ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W),
    .RR_MODE(RR_MODE)
  ) u_rr_arbiter (
    .req      (ch_strobe),
    .ptr      (ptr_q),
    .grant    (gnt_oh),
    .grant_idx(gnt_idx),
    .any      (gnt_any)
  );

  // One-hot grant masks the packed channel buses into the latch inputs.
  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_oh[i]) begin
        sel_rw    = sel_rw | ch_rw[i];
        sel_addr  = sel_addr | ch_address[i*ADDR_W +: MEM_ADDR_W];
        sel_wdata = sel_wdata | ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_next    = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (gnt_any) state_d = ST_BUSY;
      ST_BUSY: if (mem_ready || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      sel_oh_q    <= '0;
      rw_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      mem_address <= '0;
      mem_in      <= '0;
      ch_rdata    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (gnt_any) begin
            sel_oh_q    <= gnt_oh;
            rw_q        <= sel_rw;
            mem_address <= sel_addr;
            mem_in      <= sel_wdata;
            cnt_q       <= '0;
            ptr_q       <= ptr_next;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            if (rw_q) ch_rdata <= mem_out;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            if (rw_q) ch_rdata <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_enable = (state_q == ST_BUSY);
  assign mem_read   = mem_enable && rw_q;
  assign mem_write  = mem_enable && !rw_q;
  assign ch_ready   = (state_q == ST_RESP) ? sel_oh_q : '0;
  assign ch_err     = (state_q == ST_RESP) && err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
